pipeline_sequencer: RTL and testbench

Sequencing and hazard controller for the 4-stage (IF, ID, EX, WB) 8-bit processor. It sits beside the opcode decoder. It brings the pipeline out of reset through a fill phase and tracks stage-valid bits through ID/EX/WB. It redirects the PC and flushes IF/ID on a jump, and generates EX-to-ID forwarding selects plus the gated register-file write enable.

---
 rtl/pipeline_sequencer.sv | 146 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - sequencing and hazard controller for the 4-stage 8-bit pipeline
//
// Purpose: brings the pipeline out of reset through a fill phase, tracks the
// ID/EX/WB valid bits, redirects the PC and flushes IF/ID on a jump, and
// produces EX-to-ID forwarding selects and the gated register-file write enable.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   instr_id     instruction currently in ID ([7:6] op, [5:3] rd, [2:0] rs/imm)
//   pc_write     PC update enable
//   pc_sel       1 = PC loads jump_target, 0 = PC+1
//   jump_target  instr_id[5:0] passed through
//   ifid_flush   IF/ID loads a bubble on the next edge
//   fwd_a        rd operand taken from the EX result
//   fwd_b        rs operand taken from the EX result
//   wb_regwrite  register-file write enable, qualified by WB valid
//   wb_rd        register-file write address
//   illegal      valid opcode 10 present in ID
//   state        IDLE=00, FILL=01, RUN=10, FLUSH=11
module pipeline_sequencer #(
  parameter int FILL_CYCLES = 3,
  parameter int REG_ADDR_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            instr_id,
  output logic                  pc_write,
  output logic                  pc_sel,
  output logic [5:0]            jump_target,
  output logic                  ifid_flush,
  output logic                  fwd_a,
  output logic                  fwd_b,
  output logic                  wb_regwrite,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  illegal,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    RUN   = 2'b10,
    FLUSH = 2'b11
  } state_t;

  localparam logic [2:0] FILL_LOAD = 3'(FILL_CYCLES - 1);

  state_t                cur_state, next_state;
  logic [2:0]            fill_cnt, fill_cnt_next;
  logic                  id_valid;
  logic                  ex_valid, ex_regwrite;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  wb_valid, wb_regwrite_bit;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  logic [1:0]            opcode;
  logic [REG_ADDR_W-1:0] id_rd, id_rs;
  logic                  dec_valid, dec_regwrite;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  ex_fwd_ok;

  assign opcode = instr_id[7:6];
  assign id_rd  = REG_ADDR_W'(instr_id[5:3]);
  assign id_rs  = REG_ADDR_W'(instr_id[2:0]);

  // id_valid is only ever 1 in RUN: it is cleared on the edge into FLUSH, so
  // the bubble sitting in ID during FLUSH can neither jump nor forward.
  always_comb begin
    next_state    = cur_state;
    fill_cnt_next = fill_cnt;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    ifid_flush    = 1'b0;

    case (cur_state)
      IDLE: begin
        next_state    = FILL;
        fill_cnt_next = FILL_LOAD;
      end
      FILL: begin
        pc_write = 1'b1;
        if (fill_cnt == 3'd0) next_state = RUN;
        else                  fill_cnt_next = fill_cnt - 3'd1;
      end
      RUN: begin
        pc_write = 1'b1;
        if (id_valid && opcode == 2'b11) begin
          pc_sel     = 1'b1;
          ifid_flush = 1'b1;
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        pc_write   = 1'b1;
        next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  // ID decode of the entry that shifts into EX. A jump or illegal op enters
  // as valid with no write; rd is zeroed for non-writing entries.
  always_comb begin
    dec_valid    = id_valid;
    dec_regwrite = id_valid & ~opcode[1];
    dec_rd       = dec_regwrite ? id_rd : '0;
    illegal      = id_valid && (opcode == 2'b10);
    ex_fwd_ok    = ex_valid & ex_regwrite & id_valid;
    // addi's [2:0] is an immediate, so only add may forward on the rs side.
    fwd_a        = ex_fwd_ok && !opcode[1] && (ex_rd == id_rd);
    fwd_b        = ex_fwd_ok && (opcode == 2'b00) && (ex_rd == id_rs);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state       <= IDLE;
      fill_cnt        <= 3'd0;
      id_valid        <= 1'b0;
      ex_valid        <= 1'b0;
      ex_regwrite     <= 1'b0;
      ex_rd           <= '0;
      wb_valid        <= 1'b0;
      wb_regwrite_bit <= 1'b0;
      wb_rd_q         <= '0;
    end else begin
      cur_state <= next_state;
      fill_cnt  <= fill_cnt_next;
      id_valid  <= (next_state == RUN);
      if (cur_state != IDLE) begin
        wb_valid        <= ex_valid;
        wb_regwrite_bit <= ex_regwrite;
        wb_rd_q         <= ex_rd;
        ex_valid        <= dec_valid;
        ex_regwrite     <= dec_regwrite;
        ex_rd           <= dec_rd;
      end
    end
  end

  assign state       = cur_state;
  assign jump_target = instr_id[5:0];
  assign wb_regwrite = wb_valid & wb_regwrite_bit;
  assign wb_rd       = wb_rd_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;

  localparam int FILL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr_id = 8'h00;

  logic       pc_write, pc_sel, ifid_flush, fwd_a, fwd_b, wb_regwrite, illegal;
  logic [5:0] jump_target;
  logic [2:0] wb_rd;
  logic [1:0] state;

  logic       s_pc_write, s_pc_sel, s_ifid_flush, s_fwd_a, s_fwd_b, s_wb_regwrite, s_illegal;
  logic [5:0] s_jump_target;
  logic [2:0] s_wb_rd;
  logic [1:0] s_state;

  int total = 0;
  int bad = 0;

  pipeline_sequencer #(.FILL_CYCLES(FILL), .REG_ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .instr_id(instr_id),
    .pc_write(pc_write), .pc_sel(pc_sel), .jump_target(jump_target),
    .ifid_flush(ifid_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .illegal(illegal), .state(state)
  );

  pipeline_sequencer #(.FILL_CYCLES(1), .REG_ADDR_W(3)) dut_short (
    .clk(clk), .reset(reset), .instr_id(instr_id),
    .pc_write(s_pc_write), .pc_sel(s_pc_sel), .jump_target(s_jump_target),
    .ifid_flush(s_ifid_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .wb_regwrite(s_wb_regwrite), .wb_rd(s_wb_rd), .illegal(s_illegal), .state(s_state)
  );

  always #5 clk = ~clk;

  // Model: the phase follows from the number of edges since reset release;
  // ex/wb are simply what ID held one and two edges ago.
  typedef struct packed {
    logic       valid;
    logic       writes;
    logic [2:0] rd;
  } entry_t;

  int     m_edges = 0;
  bit     m_flush = 0;
  entry_t hist[$];

  function automatic logic [1:0] m_state();
    if (reset)              return 2'b00;
    if (m_edges == 0)       return 2'b00;
    if (m_edges <= FILL)    return 2'b01;
    return m_flush ? 2'b11 : 2'b10;
  endfunction

  function automatic entry_t m_at(int age);
    entry_t e;
    e = '0;
    if (age < hist.size()) e = hist[age];
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges = 0;
      m_flush = 0;
      hist.delete();
    end else begin
      logic [1:0] st;
      entry_t     cur;
      st = m_state();
      cur.valid  = (st == 2'b10);
      cur.writes = cur.valid && (instr_id[7:6] == 2'b00 || instr_id[7:6] == 2'b01);
      cur.rd     = cur.writes ? instr_id[5:3] : 3'd0;
      hist.push_front(cur);
      if (hist.size() > 4) void'(hist.pop_back());
      m_flush = cur.valid && (instr_id[7:6] == 2'b11);
      if (m_edges < 1000) m_edges++;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_check();
    logic [1:0] st;
    logic       run;
    entry_t     ex, wb;
    logic [1:0] op;
    st  = m_state();
    run = (st == 2'b10);
    ex  = m_at(0);
    wb  = m_at(1);
    op  = instr_id[7:6];
    chk("m_state",       state,       st);
    chk("m_pc_write",    pc_write,    st != 2'b00);
    chk("m_pc_sel",      pc_sel,      run && op == 2'b11);
    chk("m_ifid_flush",  ifid_flush,  run && op == 2'b11);
    chk("m_jump_target", jump_target, instr_id[5:0]);
    chk("m_illegal",     illegal,     run && op == 2'b10);
    chk("m_fwd_a", fwd_a, run && ex.writes && op[1] == 1'b0 && ex.rd == instr_id[5:3]);
    chk("m_fwd_b", fwd_b, run && ex.writes && op == 2'b00 && ex.rd == instr_id[2:0]);
    chk("m_wb_regwrite", wb_regwrite, wb.writes);
    chk("m_wb_rd",       wb_rd,       wb.rd);
  endtask

  // Drive instr_id just after an edge, check at the falling edge, then move
  // to just after the next rising edge.
  task automatic step(input logic [7:0] ins);
    instr_id = ins;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] fill_states [5];
    fill_states = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_check();
    chk("rst_state",       state,       0);
    chk("rst_pc_write",    pc_write,    0);
    chk("rst_wb_regwrite", wb_regwrite, 0);
    chk("rst_wb_rd",       wb_rd,       0);
    reset = 1'b0;

    // Reset and fill with add r1,r1
    for (int i = 0; i < 7; i++) begin
      instr_id = 8'h09;
      @(negedge clk);
      model_check();
      if (i < 5) chk("fill_state", state, fill_states[i]);
      if (i == 1) chk("short_fill_state", s_state, 2'b01);
      if (i == 2) chk("short_run_state",  s_state, 2'b10);
      if (i == 4 || i == 5) chk("fill_wb_quiet", wb_regwrite, 0);
      if (i == 6) begin
        chk("first_wb_regwrite", wb_regwrite, 1);
        chk("first_wb_rd",       wb_rd,       1);
      end
      @(posedge clk);
      #1;
    end

    // Forwarding pair
    step(8'h13);
    instr_id = 8'h22;
    @(negedge clk);
    model_check();
    chk("pair_fwd_b", fwd_b, 1);
    chk("pair_fwd_a", fwd_a, 0);
    @(posedge clk); #1;
    instr_id = 8'h62;
    @(negedge clk);
    model_check();
    chk("addi_fwd_a", fwd_a, 1);
    chk("addi_fwd_b", fwd_b, 0);
    @(posedge clk); #1;

    // Jump, then the same jump held as the flushed bubble
    instr_id = 8'hC5;
    @(negedge clk);
    model_check();
    chk("jump_pc_sel",  pc_sel,      1);
    chk("jump_flush",   ifid_flush,  1);
    chk("jump_target",  jump_target, 6'h05);
    @(posedge clk); #1;
    @(negedge clk);
    model_check();
    chk("bubble_state",  state,      2'b11);
    chk("bubble_pc_sel", pc_sel,     0);
    chk("bubble_flush",  ifid_flush, 0);
    @(posedge clk); #1;
    instr_id = 8'h00;
    @(negedge clk);
    model_check();
    chk("after_jump_state", state, 2'b10);
    @(posedge clk); #1;

    // Illegal opcode
    instr_id = 8'h89;
    @(negedge clk);
    model_check();
    chk("illegal_pulse", illegal, 1);
    chk("illegal_fwd_a", fwd_a,   0);
    chk("illegal_fwd_b", fwd_b,   0);
    @(posedge clk); #1;
    instr_id = 8'h09;
    @(negedge clk);
    model_check();
    chk("illegal_one_cycle", illegal, 0);
    @(posedge clk); #1;
    @(negedge clk);
    model_check();
    chk("illegal_no_write", wb_regwrite, 0);
    @(posedge clk); #1;

    // Mid-FLUSH reset with a writing instruction in WB
    step(8'h13);
    step(8'hC5);
    instr_id = 8'h09;
    #2;
    chk("pre_rst_state", state,       2'b11);
    chk("pre_rst_wb",    wb_regwrite, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_state", state,       0);
    chk("async_rst_wb",    wb_regwrite, 0);
    chk("async_rst_pcw",   pc_write,    0);
    #2;
    reset = 1'b0;

    // Refill after the mid-run reset
    for (int i = 0; i < 7; i++) step(8'h1B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
